// File: rtl/hazard_tracker_pkg.sv
// Shared types and constants for the hazard tracker: the in-flight
// destination tag records, the zero-register constant and counter sizing.
package hazard_tracker_pkg;

  localparam int         CNT_W    = 16;
  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Tag held in ID/EX: the destination register plus the two control bits
  // the hazard logic cares about.
  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } tag_t;

  // Later stages only need the destination and its write flag; the load
  // flag has served its purpose once the instruction leaves EX.
  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
  } wb_tag_t;

  localparam tag_t    TAG_NOP    = '0;
  localparam wb_tag_t WB_TAG_NOP = '0;

endpackage : hazard_tracker_pkg

// File: rtl/sat_counter16.sv
// Event counter: counts enabled cycles, sticks at all-ones, synchronous clear.
module sat_counter16
  import hazard_tracker_pkg::*;
(
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment until saturated.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register; the clear is folded into cnt_d so reset stays synchronous.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter16

// File: rtl/hazard_tracker.sv
// Tracks destination tags through ID/EX, EX/MEM and MEM/WB, detects
// load-use hazards against the instruction in ID, and arbitrates stall
// versus branch flush. Stall and flush cycles are counted.
module hazard_tracker
  import hazard_tracker_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             use_rt,
  input  logic [4:0]       dec_rd,
  input  logic             dec_RegWrite,
  input  logic             dec_MemRead,
  input  logic             branch_taken,
  output logic [4:0]       EX_MEM_rd,
  output logic [4:0]       MEM_WB_rd,
  output logic             EX_MEM_RegWrite,
  output logic             MEM_WB_RegWrite,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_bubble,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  tag_t    id_ex_q,  id_ex_d;
  wb_tag_t ex_mem_q, ex_mem_d;
  wb_tag_t mem_wb_q, mem_wb_d;

  logic load_use;
  logic stall_req;
  logic flush_req;

  // A load in EX whose result the ID instruction needs. $0 never creates a
  // dependency, so it is excluded here even though its tags still flow.
  assign load_use = id_ex_q.mem_read
                 && (id_ex_q.rd != REG_ZERO)
                 && ((id_ex_q.rd == IF_ID_rs) || (use_rt && (id_ex_q.rd == IF_ID_rt)));

  // Reset masks both requests; a taken branch overrides the stall because
  // the stalled instruction is about to be discarded anyway.
  assign flush_req = branch_taken && !rst_i;
  assign stall_req = load_use && !branch_taken && !rst_i;

  assign PC_write     = !stall_req;
  assign IF_ID_write  = !stall_req;
  assign ID_EX_bubble = stall_req;
  assign flush        = flush_req;

  // Tag advance: decode into ID/EX, then down the pipe, with bubbles
  // inserted by stall and both younger stages squashed by a flush.
  always_comb begin
    id_ex_d  = '{rd: dec_rd, reg_write: dec_RegWrite, mem_read: dec_MemRead};
    ex_mem_d = '{rd: id_ex_q.rd, reg_write: id_ex_q.reg_write};
    mem_wb_d = ex_mem_q;
    if (flush_req) begin
      id_ex_d  = TAG_NOP;
      ex_mem_d = WB_TAG_NOP;
    end else if (stall_req) begin
      id_ex_d  = TAG_NOP;
    end
  end

  // Tag registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_ex_q  <= TAG_NOP;
      ex_mem_q <= WB_TAG_NOP;
      mem_wb_q <= WB_TAG_NOP;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign EX_MEM_rd       = ex_mem_q.rd;
  assign EX_MEM_RegWrite = ex_mem_q.reg_write;
  assign MEM_WB_rd       = mem_wb_q.rd;
  assign MEM_WB_RegWrite = mem_wb_q.reg_write;

  sat_counter16 u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (stall_req),
    .cnt_o (stall_cnt)
  );

  sat_counter16 u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (flush_req),
    .cnt_o (flush_cnt)
  );

endmodule : hazard_tracker

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: load-use stalls, rt usage, zero
// register, flush priority, counter saturation and reset abort.
module tb_hazard_tracker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  IF_ID_rs, IF_ID_rt, dec_rd;
  logic        use_rt, dec_RegWrite, dec_MemRead, branch_taken;
  logic [4:0]  EX_MEM_rd, MEM_WB_rd;
  logic        EX_MEM_RegWrite, MEM_WB_RegWrite;
  logic        PC_write, IF_ID_write, ID_EX_bubble, flush;
  logic [15:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  hazard_tracker dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .IF_ID_rs        (IF_ID_rs),
    .IF_ID_rt        (IF_ID_rt),
    .use_rt          (use_rt),
    .dec_rd          (dec_rd),
    .dec_RegWrite    (dec_RegWrite),
    .dec_MemRead     (dec_MemRead),
    .branch_taken    (branch_taken),
    .EX_MEM_rd       (EX_MEM_rd),
    .MEM_WB_rd       (MEM_WB_rd),
    .EX_MEM_RegWrite (EX_MEM_RegWrite),
    .MEM_WB_RegWrite (MEM_WB_RegWrite),
    .PC_write        (PC_write),
    .IF_ID_write     (IF_ID_write),
    .ID_EX_bubble    (ID_EX_bubble),
    .flush           (flush),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    IF_ID_rs = 5'd0; IF_ID_rt = 5'd0; use_rt = 1'b0;
    dec_rd = 5'd0; dec_RegWrite = 1'b0; dec_MemRead = 1'b0;
    branch_taken = 1'b0;
  endtask

  // Decode an instruction into the ID-stage inputs.
  task automatic decode(input logic [4:0] rd, input logic rw, input logic mr,
                        input logic [4:0] rs, input logic [4:0] rt, input logic urt);
    dec_rd = rd; dec_RegWrite = rw; dec_MemRead = mr;
    IF_ID_rs = rs; IF_ID_rt = rt; use_rt = urt;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    decode(5'd8, 1'b1, 1'b1, 5'd8, 5'd8, 1'b1);
    branch_taken = 1'b1;
    tick();
    tick();
    n_tests++; if (PC_write !== 1'b1)       begin n_fail++; $display("FAIL reset_pc_write: got %b want 1", PC_write); end
    n_tests++; if (IF_ID_write !== 1'b1)    begin n_fail++; $display("FAIL reset_if_id_write: got %b want 1", IF_ID_write); end
    n_tests++; if (ID_EX_bubble !== 1'b0)   begin n_fail++; $display("FAIL reset_bubble: got %b want 0", ID_EX_bubble); end
    n_tests++; if (flush !== 1'b0)          begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush); end
    n_tests++; if ({EX_MEM_rd, EX_MEM_RegWrite, MEM_WB_rd, MEM_WB_RegWrite} !== 12'd0)
      begin n_fail++; $display("FAIL reset_tags: got %h want 000", {EX_MEM_rd, EX_MEM_RegWrite, MEM_WB_rd, MEM_WB_RegWrite}); end
    n_tests++; if ({stall_cnt, flush_cnt} !== 32'd0)
      begin n_fail++; $display("FAIL reset_counters: got %h/%h want 0/0", stall_cnt, flush_cnt); end
    rst_i = 1'b0;
    clear_inputs();
  endtask

  // lw $8 then add $9,$8,$1.
  task automatic test_load_use();
    do_reset();
    decode(5'd8, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
    #1;
    n_tests++; if (PC_write !== 1'b1) begin n_fail++; $display("FAIL lu_no_early_stall: got %b want 1", PC_write); end
    tick();
    decode(5'd9, 1'b1, 1'b0, 5'd8, 5'd1, 1'b1);
    #1;
    n_tests++; if (PC_write !== 1'b0)     begin n_fail++; $display("FAIL lu_pc_write: got %b want 0", PC_write); end
    n_tests++; if (IF_ID_write !== 1'b0)  begin n_fail++; $display("FAIL lu_if_id_write: got %b want 0", IF_ID_write); end
    n_tests++; if (ID_EX_bubble !== 1'b1) begin n_fail++; $display("FAIL lu_bubble: got %b want 1", ID_EX_bubble); end
    n_tests++; if (flush !== 1'b0)        begin n_fail++; $display("FAIL lu_flush: got %b want 0", flush); end
    tick();
    // Load now in EX/MEM, bubble in ID/EX; the stall has ended.
    n_tests++; if (PC_write !== 1'b1) begin n_fail++; $display("FAIL lu_one_cycle: got %b want 1", PC_write); end
    n_tests++; if ({EX_MEM_rd, EX_MEM_RegWrite} !== {5'd8, 1'b1})
      begin n_fail++; $display("FAIL lu_ex_mem_load: got %0d/%b want 8/1", EX_MEM_rd, EX_MEM_RegWrite); end
    n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
    tick();
    n_tests++; if (EX_MEM_RegWrite !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_ex_mem: got %b want 0", EX_MEM_RegWrite); end
    n_tests++; if ({MEM_WB_rd, MEM_WB_RegWrite} !== {5'd8, 1'b1})
      begin n_fail++; $display("FAIL lu_mem_wb_load: got %0d/%b want 8/1", MEM_WB_rd, MEM_WB_RegWrite); end
    n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt_hold: got %0d want 1", stall_cnt); end
    clear_inputs();
  endtask

  // lw $8 then sw $8: the rt match counts only when rt is read.
  task automatic test_use_rt();
    do_reset();
    decode(5'd8, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    decode(5'd0, 1'b0, 1'b0, 5'd2, 5'd8, 1'b1);
    #1;
    n_tests++; if (ID_EX_bubble !== 1'b1) begin n_fail++; $display("FAIL rt_used_stall: got %b want 1", ID_EX_bubble); end
    do_reset();
    decode(5'd8, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    decode(5'd0, 1'b0, 1'b0, 5'd2, 5'd8, 1'b0);
    #1;
    n_tests++; if ({PC_write, ID_EX_bubble} !== 2'b10)
      begin n_fail++; $display("FAIL rt_unused_no_stall: got pc=%b bub=%b want 1/0", PC_write, ID_EX_bubble); end
    tick();
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rt_unused_cnt: got %0d want 0", stall_cnt); end
    clear_inputs();
  endtask

  // lw $0 then add $9,$0,$0: no stall, but the $0 tag still travels.
  task automatic test_zero_reg();
    do_reset();
    decode(5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    decode(5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1);
    #1;
    n_tests++; if ({PC_write, ID_EX_bubble} !== 2'b10)
      begin n_fail++; $display("FAIL zero_no_stall: got pc=%b bub=%b want 1/0", PC_write, ID_EX_bubble); end
    tick();
    n_tests++; if ({EX_MEM_rd, EX_MEM_RegWrite} !== {5'd0, 1'b1})
      begin n_fail++; $display("FAIL zero_ex_mem: got %0d/%b want 0/1", EX_MEM_rd, EX_MEM_RegWrite); end
    clear_inputs();
    tick();
    n_tests++; if ({MEM_WB_rd, MEM_WB_RegWrite} !== {5'd0, 1'b1})
      begin n_fail++; $display("FAIL zero_mem_wb: got %0d/%b want 0/1", MEM_WB_rd, MEM_WB_RegWrite); end
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL zero_stall_cnt: got %0d want 0", stall_cnt); end
  endtask

  // Taken branch in the same cycle as a load-use hazard.
  task automatic test_flush_priority();
    do_reset();
    decode(5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    decode(5'd8, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    decode(5'd9, 1'b1, 1'b0, 5'd8, 5'd1, 1'b1);
    branch_taken = 1'b1;
    #1;
    n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL fl_flush: got %b want 1", flush); end
    n_tests++; if ({PC_write, IF_ID_write, ID_EX_bubble} !== 3'b110)
      begin n_fail++; $display("FAIL fl_no_stall: got %b want 110", {PC_write, IF_ID_write, ID_EX_bubble}); end
    tick();
    n_tests++; if ({EX_MEM_rd, EX_MEM_RegWrite} !== 6'd0)
      begin n_fail++; $display("FAIL fl_ex_mem_zero: got %0d/%b want 0/0", EX_MEM_rd, EX_MEM_RegWrite); end
    n_tests++; if ({MEM_WB_rd, MEM_WB_RegWrite} !== {5'd5, 1'b1})
      begin n_fail++; $display("FAIL fl_mem_wb_shift: got %0d/%b want 5/1", MEM_WB_rd, MEM_WB_RegWrite); end
    n_tests++; if ({flush_cnt, stall_cnt} !== {16'd1, 16'd0})
      begin n_fail++; $display("FAIL fl_counters: got flush=%0d stall=%0d want 1/0", flush_cnt, stall_cnt); end
    clear_inputs();
    tick();
    // The zeroed ID/EX tag emerges here, and MEM/WB receives the zeroed EX/MEM.
    n_tests++; if ({EX_MEM_rd, EX_MEM_RegWrite} !== 6'd0)
      begin n_fail++; $display("FAIL fl_id_ex_zero: got %0d/%b want 0/0", EX_MEM_rd, EX_MEM_RegWrite); end
    n_tests++; if (MEM_WB_RegWrite !== 1'b0) begin n_fail++; $display("FAIL fl_mem_wb_zero: got %b want 0", MEM_WB_RegWrite); end
  endtask

  // Hazard held for 70000 cycles: the stall counter must stop at all-ones.
  task automatic test_saturation();
    do_reset();
    force dut.load_use = 1'b1;
    repeat (100) tick();
    n_tests++; if (stall_cnt !== 16'd100) begin n_fail++; $display("FAIL sat_count_100: got %0d want 100", stall_cnt); end
    repeat (69900) tick();
    n_tests++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_at_max: got %h want ffff", stall_cnt); end
    n_tests++; if (PC_write !== 1'b0) begin n_fail++; $display("FAIL sat_still_stall: got %b want 0", PC_write); end
    release dut.load_use;
    clear_inputs();
    tick();
    n_tests++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", stall_cnt); end
    n_tests++; if (flush_cnt !== 16'd0) begin n_fail++; $display("FAIL sat_flush_cnt: got %0d want 0", flush_cnt); end
  endtask

  // Reset arriving during a stall, then during a flush.
  task automatic test_reset_mid_stall();
    do_reset();
    decode(5'd8, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    decode(5'd9, 1'b1, 1'b0, 5'd8, 5'd1, 1'b1);
    tick();
    decode(5'd8, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    decode(5'd9, 1'b1, 1'b0, 5'd8, 5'd1, 1'b1);
    #1;
    n_tests++; if (PC_write !== 1'b0) begin n_fail++; $display("FAIL rs_pre_stall: got %b want 0", PC_write); end
    n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL rs_pre_cnt: got %0d want 1", stall_cnt); end
    rst_i = 1'b1;
    #1;
    n_tests++; if ({PC_write, IF_ID_write, ID_EX_bubble} !== 3'b110)
      begin n_fail++; $display("FAIL rs_comb_release: got %b want 110", {PC_write, IF_ID_write, ID_EX_bubble}); end
    tick();
    n_tests++; if ({EX_MEM_rd, EX_MEM_RegWrite, MEM_WB_rd, MEM_WB_RegWrite} !== 12'd0)
      begin n_fail++; $display("FAIL rs_tags: got %h want 000", {EX_MEM_rd, EX_MEM_RegWrite, MEM_WB_rd, MEM_WB_RegWrite}); end
    n_tests++; if ({stall_cnt, flush_cnt} !== 32'd0)
      begin n_fail++; $display("FAIL rs_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    n_tests++; if (PC_write !== 1'b1) begin n_fail++; $display("FAIL rs_pc_write: got %b want 1", PC_write); end
    branch_taken = 1'b1;
    #1;
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rs_flush_masked: got %b want 0", flush); end
    tick();
    n_tests++; if (flush_cnt !== 16'd0) begin n_fail++; $display("FAIL rs_flush_cnt: got %0d want 0", flush_cnt); end
    rst_i = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_i = 1'b1;
    #2;
    test_reset();
    test_load_use();
    test_use_rt();
    test_zero_reg();
    test_flush_priority();
    test_saturation();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_hazard_tracker

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 The block SHALL have port clk_i, input, 1 bit: rising-edge clock.
REQ-002 The block SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have port IF_ID_rs, input, 5 bits: rs field of the instruction in ID.
REQ-004 The block SHALL have port IF_ID_rt, input, 5 bits: rt field of the instruction in ID.
REQ-005 The block SHALL have port use_rt, input, 1 bit: the ID instruction reads rt.
REQ-006 The block SHALL have port dec_rd, input, 5 bits: destination register decoded in ID.
REQ-007 The block SHALL have port dec_RegWrite, input, 1 bit: the ID instruction writes a register.
REQ-008 The block SHALL have port dec_MemRead, input, 1 bit: the ID instruction is a load.
REQ-009 The block SHALL have port branch_taken, input, 1 bit: branch resolved taken in MEM.
REQ-010 The block SHALL have ports EX_MEM_rd and MEM_WB_rd, output, 5 bits each: in-flight destination tags for the forwarding logic.
REQ-011 The block SHALL have ports EX_MEM_RegWrite and MEM_WB_RegWrite, output, 1 bit each: tag valid/write flags.
REQ-012 The block SHALL have ports PC_write and IF_ID_write, output, 1 bit each: 0 holds the PC and the IF/ID register.
REQ-013 The block SHALL have port ID_EX_bubble, output, 1 bit: 1 zeroes the control bits entering ID/EX.
REQ-014 The block SHALL have port flush, output, 1 bit: 1 clears IF/ID, ID/EX and EX/MEM.
REQ-015 The block SHALL have ports stall_cnt and flush_cnt, output, 16 bits each: event counters.

Function
REQ-016 Three tag stages SHALL be registered: ID/EX {rd, RegWrite, MemRead}, EX/MEM {rd, RegWrite} and MEM/WB {rd, RegWrite}.
REQ-017 Tags SHALL advance one stage per clk_i edge: decode inputs to ID/EX, ID/EX to EX/MEM, and EX/MEM to MEM/WB.
REQ-018 Load-use hazard SHALL be defined as ID/EX.MemRead and ID/EX.rd != 0 and (ID/EX.rd == IF_ID_rs, or use_rt and ID/EX.rd == IF_ID_rt).
REQ-019 On a load-use hazard, the block SHALL drive PC_write=0, IF_ID_write=0 and ID_EX_bubble=1, combinationally in the same cycle.
REQ-020 On a load-use hazard, the ID/EX tag SHALL load {0,0,0} at the next edge.
REQ-021 A load-use stall SHALL last exactly one cycle, because the bubble clears ID/EX.MemRead.
REQ-022 When branch_taken=1, the block SHALL drive flush=1 combinationally.
REQ-023 When branch_taken=1, the ID/EX and EX/MEM tags SHALL load {0,0,0} at the next edge, and MEM/WB SHALL load the current EX/MEM tag.
REQ-024 When branch_taken coincides with a load-use hazard, flush SHALL win: PC_write=1, IF_ID_write=1, ID_EX_bubble=0, and only flush_cnt increments.
REQ-025 A tag with rd=0 SHALL propagate unchanged; zero-register filtering is the consumer's job, except in the hazard test of REQ-018.
REQ-026 stall_cnt SHALL increment by 1 per stall cycle and saturate at 16'hFFFF.
REQ-027 flush_cnt SHALL increment by 1 per flush cycle and saturate at 16'hFFFF.
REQ-028 EX_MEM_* and MEM_WB_* outputs SHALL be the registered tag values directly, with zero combinational delay.

Reset
REQ-029 When rst_i=1 at an edge, all tag registers and both counters SHALL become 0.
REQ-030 While rst_i=1, outputs SHALL be PC_write=1, IF_ID_write=1, ID_EX_bubble=0 and flush=0, regardless of the other inputs.
REQ-031 Reset asserted mid-stall or mid-flush SHALL abort it, with no counter increment on that edge.

Structure
REQ-032 A shared package SHALL hold the tag record (rd, RegWrite, MemRead), the constant REG_ZERO=5'd0 and the counter width 16.
REQ-033 One sub-module, sat_counter16 (enable, synchronous clear, saturate), SHALL be instantiated twice.
REQ-034 Hazard and flush decode SHALL be combinational; everything else SHALL be registered.

Verification
REQ-035 The bench SHALL cover: lw $8 followed by add $9,$8,$1 -> one cycle with PC_write=0 and ID_EX_bubble=1, EX_MEM_RegWrite=0 one cycle later, stall_cnt=1.
REQ-036 The bench SHALL cover: lw $8 followed by sw $8 with use_rt=1 -> stall; the same with use_rt=0 and rt=8 -> no stall.
REQ-037 The bench SHALL cover: lw $0 followed by add $9,$0,$0 -> no stall; tag rd=0 still reaches MEM_WB_rd at cycle +3.
REQ-038 The bench SHALL cover: branch_taken together with a load-use hazard -> flush=1, PC_write=1, next-edge ID/EX and EX/MEM tags zero, flush_cnt=1, stall_cnt=0.
REQ-039 The bench SHALL cover: continuous hazard forced for 70000 cycles -> stall_cnt holds at 16'hFFFF.
REQ-040 The bench SHALL cover: rst_i=1 during a stall cycle -> next edge has all tags 0, counters 0 and PC_write=1.
